// File: rtl/pe3x3_psum_collector.sv
// Partial-sum collector for the 3x3 PE: accumulates KROWS beats per tile, stitches the
// 2-lane overlap between adjacent tiles and emits 7-lane body beats plus a row tail.
//
// state | meaning
// ACC   | accepting partial-sum beats, accumulating over kernel rows
// EMIT  | body beat of a finished tile presented downstream
// TAIL  | end-of-row tail beat (lanes 0..1) presented downstream
module pe3x3_psum_collector #(
    parameter int IW     = 24,
    parameter int FW     = 8,
    parameter int IN_NUM = 9,
    parameter int STEP   = 7,
    parameter int KROWS  = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic [IN_NUM*(IW+FW)-1:0]    psum_i,
    input  logic                         psum_valid_i,
    output logic                         psum_ready_o,
    input  logic                         tile_last_i,
    output logic [STEP*(IW+FW)-1:0]      out_data_o,
    output logic                         out_valid_o,
    output logic                         out_tail_o,
    input  logic                         out_ready_i
);

    localparam int W  = IW + FW;
    localparam int KW = (KROWS > 1) ? $clog2(KROWS) : 1;

    typedef enum logic [1:0] {ACC, EMIT, TAIL} state_t;

    state_t               state;
    logic [W-1:0]         acc   [IN_NUM];
    logic [W-1:0]         carry [2];
    logic [KW-1:0]        kcnt;
    logic                 last_f;
    logic [STEP*W-1:0]    out_data;

    logic [W-1:0]         sum_in [IN_NUM];
    logic [STEP*W-1:0]    body_data;
    logic [STEP*W-1:0]    tail_data;
    logic                 beat_acc;
    logic                 beat_final;

    assign psum_ready_o = (state == ACC);
    assign out_valid_o  = (state != ACC);
    assign out_tail_o   = (state == TAIL);
    assign out_data_o   = out_data;

    assign beat_acc   = psum_valid_i & psum_ready_o;
    assign beat_final = (kcnt == KW'(KROWS - 1));

    // First kernel row overwrites the accumulator rather than adding to stale data.
    always_comb begin
        for (int k = 0; k < IN_NUM; k++) begin
            sum_in[k] = (kcnt == '0) ? psum_i[k*W +: W] : acc[k] + psum_i[k*W +: W];
        end
    end

    always_comb begin
        body_data = '0;
        for (int k = 0; k < STEP; k++) begin
            body_data[k*W +: W] = sum_in[k];
        end
        body_data[0 +: W] = sum_in[0] + carry[0];
        body_data[W +: W] = sum_in[1] + carry[1];
    end

    always_comb begin
        tail_data         = '0;
        tail_data[0 +: W] = acc[IN_NUM-2];
        tail_data[W +: W] = acc[IN_NUM-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACC;
            kcnt     <= '0;
            last_f   <= 1'b0;
            out_data <= '0;
            carry[0] <= '0;
            carry[1] <= '0;
            for (int k = 0; k < IN_NUM; k++) begin
                acc[k] <= '0;
            end
        end else if (clear_i) begin
            state    <= ACC;
            kcnt     <= '0;
            last_f   <= 1'b0;
            out_data <= '0;
            carry[0] <= '0;
            carry[1] <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (beat_acc) begin
                        for (int k = 0; k < IN_NUM; k++) begin
                            acc[k] <= sum_in[k];
                        end
                        if (beat_final) begin
                            kcnt     <= '0;
                            last_f   <= tile_last_i;
                            out_data <= body_data;
                            state    <= EMIT;
                        end else begin
                            kcnt <= kcnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        carry[0] <= acc[IN_NUM-2];
                        carry[1] <= acc[IN_NUM-1];
                        if (last_f) begin
                            out_data <= tail_data;
                            state    <= TAIL;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                TAIL: begin
                    if (out_ready_i) begin
                        carry[0] <= '0;
                        carry[1] <= '0;
                        last_f   <= 1'b0;
                        state    <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_pe3x3_psum_collector.sv
// Scoreboard bench for pe3x3_psum_collector: expected beats are queued as tiles are
// driven and compared as the collector hands them out.
module tb_pe3x3_psum_collector;

    localparam int IW = 24, FW = 8, W = 32, IN_NUM = 9, STEP = 7, KROWS = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clear_i = 1'b0;
    logic [IN_NUM*W-1:0]     psum_i = '0;
    logic                    psum_valid_i = 1'b0;
    logic                    psum_ready_o;
    logic                    tile_last_i = 1'b0;
    logic [STEP*W-1:0]       out_data_o;
    logic                    out_valid_o;
    logic                    out_tail_o;
    logic                    out_ready_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [STEP*W:0] exp_q [$];

    pe3x3_psum_collector #(.IW(IW), .FW(FW), .IN_NUM(IN_NUM), .STEP(STEP), .KROWS(KROWS)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .psum_i(psum_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
        .tile_last_i(tile_last_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_tail_o(out_tail_o),
        .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [IN_NUM*W-1:0] rep(input logic [W-1:0] v);
        logic [IN_NUM*W-1:0] r;
        for (int k = 0; k < IN_NUM; k++) r[k*W +: W] = v;
        return r;
    endfunction

    function automatic logic [IN_NUM*W-1:0] ramp(input logic [W-1:0] st);
        logic [IN_NUM*W-1:0] r;
        for (int k = 0; k < IN_NUM; k++) r[k*W +: W] = W'(k) * st;
        return r;
    endfunction

    // {tail flag, lanes}: lanes 2..6 = base + k*st
    function automatic logic [STEP*W:0] body(input logic [W-1:0] l0, l1, base, st);
        logic [STEP*W:0] r;
        r = '0;
        for (int k = 2; k < STEP; k++) r[k*W +: W] = base + W'(k) * st;
        r[0 +: W] = l0;
        r[W +: W] = l1;
        return r;
    endfunction

    function automatic logic [STEP*W:0] tail(input logic [W-1:0] l0, l1);
        logic [STEP*W:0] r;
        r = '0;
        r[STEP*W]  = 1'b1;
        r[0 +: W]  = l0;
        r[W +: W]  = l1;
        return r;
    endfunction

    // Entered and left at a falling edge.
    task automatic send_beat(input logic [IN_NUM*W-1:0] d, input logic last);
        int cnt = 0;
        psum_i = d;
        tile_last_i = last;
        psum_valid_i = 1'b1;
        while (!psum_ready_o && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!psum_ready_o) begin
            vectors++;
            miscompares++;
            $display("FAIL send_beat timeout: psum_ready_o=%b want 1", psum_ready_o);
        end
        @(negedge clk);
        psum_valid_i = 1'b0;
        tile_last_i = 1'b0;
    endtask

    task automatic get_out(output logic [STEP*W:0] obs);
        int cnt = 0;
        out_ready_i = 1'b1;
        while (!out_valid_o && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!out_valid_o) begin
            vectors++;
            miscompares++;
            $display("FAIL get_out timeout: out_valid_o=%b want 1", out_valid_o);
            obs = 'x;
        end else begin
            obs = {out_tail_o, out_data_o};
        end
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic send_tile(input logic [IN_NUM*W-1:0] b0, b1, b2, input logic last);
        send_beat(b0, 1'b0);
        send_beat(b1, 1'b0);
        send_beat(b2, last);
    endtask

    task automatic test_reset();
        vectors += 4;
        if (psum_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset psum_ready_o: got %b want 1", psum_ready_o); end
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset out_valid_o: got %b want 0", out_valid_o); end
        if (out_tail_o !== 1'b0) begin miscompares++; $display("FAIL reset out_tail_o: got %b want 0", out_tail_o); end
        if (out_data_o !== '0) begin miscompares++; $display("FAIL reset out_data_o: got %h want 0", out_data_o); end
    endtask

    task automatic test_single_tile();
        logic [STEP*W:0] obs, exp;
        exp_q.push_back(body(32'h600, 32'h600, 32'h600, 0));
        exp_q.push_back(tail(32'h600, 32'h600));
        send_tile(rep(32'h100), rep(32'h200), rep(32'h300), 1'b1);
        vectors++;
        if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL latency out_valid_o: got %b want 1", out_valid_o); end
        repeat (2) begin
            get_out(obs);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL single_tile out: got %h want %h", obs, exp); end
        end
    endtask

    task automatic test_two_tile();
        logic [STEP*W:0] obs, exp;
        exp_q.push_back(body(32'h0, 32'h300, 32'h0, 32'h300));
        send_tile(ramp(32'h100), ramp(32'h100), ramp(32'h100), 1'b0);
        get_out(obs);
        exp = exp_q.pop_front();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL stitch tile0: got %h want %h", obs, exp); end
        exp_q.push_back(body(32'h1500, 32'h1B00, 32'h0, 32'h300));
        exp_q.push_back(tail(32'h1500, 32'h1800));
        send_tile(ramp(32'h100), ramp(32'h100), ramp(32'h100), 1'b1);
        repeat (2) begin
            get_out(obs);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL stitch tile1: got %h want %h", obs, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [STEP*W:0] obs, exp;
        exp_q.push_back(body(32'h300, 32'h300, 32'h300, 0));
        send_tile(rep(32'h100), rep(32'h100), rep(32'h100), 1'b0);
        exp = exp_q.pop_front();
        psum_i = rep(32'h100);
        psum_valid_i = 1'b1;
        out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({out_tail_o, out_data_o} !== exp || psum_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL backpressure hold c%0d: got %h rdy=%b vld=%b want %h rdy=0 vld=1",
                         c, {out_tail_o, out_data_o}, psum_ready_o, out_valid_o, exp);
            end
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        vectors++;
        if (psum_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure release: rdy=%b vld=%b want rdy=1 vld=0", psum_ready_o, out_valid_o);
        end
        exp_q.push_back(body(32'h600, 32'h600, 32'h300, 0));
        exp_q.push_back(tail(32'h300, 32'h300));
        send_tile(rep(32'h100), rep(32'h100), rep(32'h100), 1'b1);
        repeat (2) begin
            get_out(obs);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL backpressure next tile: got %h want %h", obs, exp); end
        end
    endtask

    task automatic test_wrap();
        logic [STEP*W:0] obs, exp;
        exp_q.push_back(body(32'h0, 32'h0, 32'h0, 0));
        exp_q.push_back(tail(32'h0, 32'h0));
        send_tile(rep(32'hFFFFFF00), rep(32'h100), rep(32'h0), 1'b1);
        repeat (2) begin
            get_out(obs);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL wrap: got %h want %h", obs, exp); end
        end
    endtask

    task automatic test_clear();
        logic [STEP*W:0] obs, exp;
        // leaves a non-zero carry behind so the clear has something to wipe
        exp_q.push_back(body(32'h300, 32'h300, 32'h300, 0));
        send_tile(rep(32'h100), rep(32'h100), rep(32'h100), 1'b0);
        get_out(obs);
        exp = exp_q.pop_front();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL clear pre-tile: got %h want %h", obs, exp); end
        send_beat(rep(32'h500), 1'b0);
        send_beat(rep(32'h500), 1'b0);
        psum_i = rep(32'h700);
        psum_valid_i = 1'b1;
        tile_last_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        psum_valid_i = 1'b0;
        tile_last_i = 1'b0;
        vectors += 2;
        if (out_data_o !== '0) begin miscompares++; $display("FAIL clear out_data_o: got %h want 0", out_data_o); end
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL clear out_valid_o: got %b want 0", out_valid_o); end
        exp_q.push_back(body(32'h300, 32'h300, 32'h300, 0));
        exp_q.push_back(tail(32'h300, 32'h300));
        send_tile(rep(32'h100), rep(32'h100), rep(32'h100), 1'b1);
        repeat (2) begin
            get_out(obs);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL clear post-tile: got %h want %h", obs, exp); end
        end
    endtask

    task automatic test_reset_emit();
        logic [STEP*W:0] obs, exp;
        send_tile(rep(32'h200), rep(32'h200), rep(32'h200), 1'b0);
        vectors++;
        if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL reset_emit pre: out_valid_o=%b want 1", out_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({psum_ready_o, out_valid_o, out_tail_o, out_data_o} !== {3'b100, {(STEP*W){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_emit async: rdy=%b vld=%b tail=%b data=%h want rdy=1 vld=0 tail=0 data=0",
                     psum_ready_o, out_valid_o, out_tail_o, out_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(body(32'h300, 32'h300, 32'h300, 0));
        exp_q.push_back(tail(32'h300, 32'h300));
        send_tile(rep(32'h100), rep(32'h100), rep(32'h100), 1'b1);
        repeat (2) begin
            get_out(obs);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL reset_emit next tile: got %h want %h", obs, exp); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_tile();
        test_two_tile();
        test_backpressure();
        test_wrap();
        test_clear();
        test_reset_emit();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe3x3_psum_collector.md
# pe3x3_psum_collector

Downstream consumer of the 9-lane partial-sum bus produced by the 3x3 processing element. It accumulates the per-kernel-row partial sums of one output tile over `KROWS` input beats. It stitches the 2-lane overlap between horizontally adjacent tiles and emits 7 finished Q24.8 outputs per tile over a valid/ready handshake, plus a 2-lane tail beat at the end of each output row.

## Interface
Parameters:
- `IW`, 24, integer bits of each Q24.8 value
- `FW`, 8, fraction bits; lane width `W = IW+FW`
- `IN_NUM`, 9, lanes on the partial-sum input bus
- `STEP`, 7, output lanes per body beat (`IN_NUM-2`)
- `KROWS`, 3, input beats (kernel rows) summed per tile

Ports:
- `clk`, in, 1: clock
- `rst_n`, in, 1: reset, asynchronous, active-low
- `clear_i`, in, 1: synchronous abort; returns the block to its idle state
- `psum_i`, in, `IN_NUM*W`: partial sums; lane k is at `[k*W +: W]`
- `psum_valid_i`, in, 1: `psum_i` is valid
- `psum_ready_o`, out, 1: block accepts a beat
- `tile_last_i`, in, 1: qualifies the beat; marks the tile as last in the output row; sampled only on the final (`KROWS`-th) beat of a tile
- `out_data_o`, out, `STEP*W`: finished outputs; lane k is at `[k*W +: W]`
- `out_valid_o`, out, 1: `out_data_o` is valid
- `out_tail_o`, out, 1: current output beat is a row tail
- `out_ready_i`, in, 1: downstream accepts the output beat

## Operation
- Registers:
  - `acc[0..8]` (W bits each)
  - `carry[0..1]`
  - `kcnt` (0..KROWS-1)
  - `last_f`
  - output register `out_data`
  - FSM state
- All adds are W-bit two's-complement and wrap modulo 2^W. There is no saturation and no rescaling, because Q24.8 + Q24.8 stays Q24.8.
- FSM states: ACC, EMIT, TAIL.
- ACC:
  - `psum_ready_o = 1`.
  - On an accepted beat (`psum_valid_i & psum_ready_o`):
    - If `kcnt == 0`: `acc[k] <= psum[k]`.
    - Otherwise: `acc[k] <= acc[k] + psum[k]`.
    - `kcnt` increments.
  - On the accepted beat with `kcnt == KROWS-1`:
    - `kcnt <= 0`.
    - `last_f <= tile_last_i`.
    - Load `out_data` lanes 0..6, where `s[k] = acc[k] + psum[k]`:
      - Lane 0 = `s[0] + carry[0]`.
      - Lane 1 = `s[1] + carry[1]`.
      - Lanes 2..6 = `s[2..6]`.
    - `carry_next[0..1] <= s[7..8]`, held in `acc[7..8]`.
    - Go to EMIT.
- EMIT:
  - `out_valid_o = 1`, `out_tail_o = 0`, `psum_ready_o = 0`.
  - On `out_ready_i`:
    - `carry <= acc[7..8]`.
    - If `last_f = 1`: load `out_data` lanes 0..1 with `acc[7..8]` and lanes 2..6 with 0, then go to TAIL.
    - Otherwise go to ACC.
- TAIL:
  - `out_valid_o = 1`, `out_tail_o = 1`, `psum_ready_o = 0`.
  - On `out_ready_i`: `carry <= 0`, `last_f <= 0`, go to ACC.
- The first tile of every row therefore sees `carry = 0`. Carry is zero after reset and after every TAIL.
- `psum_ready_o` is a combinational decode of the state (ACC only). `out_valid_o` and `out_tail_o` decode the state. `out_data_o` is a register.
- `clear_i = 1`, in any state:
  - Next state is ACC.
  - `kcnt`, `carry`, `last_f` and `out_data` go to 0.
  - An input beat presented in the same cycle is discarded.
  - `clear_i` has priority over every handshake.
- `tile_last_i` on non-final beats is ignored.

## Timing
- Reset values:
  - State ACC, so `psum_ready_o = 1`.
  - `out_valid_o = 0`, `out_tail_o = 0`, `out_data_o = 0`.
  - All accumulators, carry, `kcnt` and `last_f` are 0.
- Latency: `out_valid_o` rises in the cycle after the final beat of a tile is accepted.
- Throughput:
  - `KROWS+1` cycles per tile at best, since no input is accepted during EMIT.
  - One extra cycle per row for TAIL.
- Handshake rules:
  - Under `out_ready_i = 0`, `out_data_o`, `out_valid_o` and `out_tail_o` hold stable.
  - `psum_i` is not sampled when `psum_ready_o = 0`.
- Reset asserted mid-tile or mid-EMIT: all state returns to the reset values asynchronously, and partial sums are lost.

## Test plan
- **Single tile:** `KROWS=3`, `tile_last_i=1`, beats with every lane = 0x100, 0x200, 0x300.
  - Body beat: lanes 0..6 = 0x600, `out_tail_o=0`.
  - Then tail beat: lanes 0,1 = 0x600, lanes 2..6 = 0, `out_tail_o=1`.
- **Two-tile stitch:** each beat has lane k = k·0x100; tile 0 has `tile_last_i=0`, tile 1 has `tile_last_i=1`.
  - Tile 0 body: lane k = 0x300·k.
  - Tile 1 body: lane 0 = 0x1500, lane 1 = 0x1B00, lanes 2..6 = 0x300·k.
  - Tail: 0x1500, 0x1800.
- **Backpressure:** hold `out_ready_i=0` for 5 cycles in EMIT while `psum_valid_i=1`.
  - `out_data_o` is stable, `psum_ready_o=0`, and no beat is consumed.
  - The beat is accepted the cycle after the EMIT handshake.
- **Wrap arithmetic:** beats with lane values 0xFFFFFF00, 0x100, 0 → body lanes = 0x00000000.
- **clear_i mid-tile:** pulse `clear_i` after 2 accepted beats, then send 3 beats of 0x100.
  - Body lanes = 0x300.
  - Carry is zero, so lanes 0..1 = 0x300.
- **Reset in EMIT:** drop `rst_n` while `out_valid_o=1`.
  - Outputs go to their reset values immediately.
  - The next tile produces a fresh sum with no carry.
